iomem_uart: RTL
===============

// Module: iomem_uart
// PURPOSE
//  UART peripheral that responds on the SoC iomem bus (valid/ready/addr/rdata/wdata/wstrb).
//  It is the target end of the bus that the core drives for addresses at or above 0x03000000.
//  The SoC decodes the peripheral base address; this block decodes only iomem_addr[3:2].
//  Contains an 8N1 transmitter fed by a TX FIFO and an optional receiver with a 1-byte holding register.
// PARAMETERS
//  TX_FIFO_DEPTH  3    log2 of the TX FIFO entry count (default 8 entries)
//  DIV_RESET      104  reset value of DIV, in clocks per bit
// PORTS
//  clk          in   1   clock; all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  iomem_valid  in   1   request valid; initiator holds it until iomem_ready is seen
//  iomem_ready  out  1   one-cycle acknowledge
//  iomem_addr   in   32  byte address; only bits [3:2] are decoded
//  iomem_rdata  out  32  read data; valid while iomem_ready=1
//  iomem_wdata  in   32  write data
//  iomem_wstrb  in   4   byte write strobes; 0 = read
//  uart_tx      out  1   serial output; idles high
//  uart_rx      in   1   serial input; asynchronous
// BEHAVIOUR
//  Reset values: iomem_ready=0, iomem_rdata=0, uart_tx=1, DIV=DIV_RESET.
//    FIFO and RX holder empty, all sticky flags 0, TX and RX FSMs in IDLE.
//  Handshake: on a posedge with iomem_valid=1 and iomem_ready=0:
//    - iomem_ready<=1 and iomem_rdata<=register value.
//    - All side effects (push, pop, W1C) commit at this same edge.
//    - iomem_ready returns to 0 on the next cycle, even if iomem_valid is still 1.
//    - Result: 1 wait state, and exactly one access per ready pulse.
//  Register map (addr[3:2]):
//    0 DATA
//      Write with wstrb[0]=1: push wdata[7:0] to the TX FIFO.
//      Read: if RX_VALID, return {24'h0,byte} and clear RX_VALID; otherwise return 32'hFFFFFFFF.
//    1 STATUS
//      Read-only bits: [0] TX_FULL, [1] TX_EMPTY (FIFO empty), [2] TX_BUSY (FIFO non-empty or FSM not IDLE), [3] RX_VALID.
//      Sticky bits, write-1-to-clear under wstrb[0]: [4] TX_OVF, [5] RX_OVR, [6] RX_FERR.
//      All other bits read 0.
//    2 DIV
//      [15:0] clocks per bit, byte-strobed write.
//      A resulting value below 4 is stored as 4. Bits [31:16] read 0.
//    3 Reserved: reads 0, writes ignored.
//  TX FIFO: 2**TX_FIFO_DEPTH entries with wrapping read/write pointers.
//    A push while full (full evaluated before any same-cycle pop) is dropped and sets TX_OVF.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//    Each bit lasts exactly DIV clocks. DIV is latched on leaving IDLE; a DIV write mid-frame affects the next frame.
//    In IDLE with the FIFO non-empty, the FSM pops one byte and drives the start bit on the following cycle.
//    Back-to-back frames have no idle gap. A frame is 10*DIV clocks.
//  RX FSM (IOMEM_UART_RX_EN only):
//    - uart_rx passes through a 2-flop synchronizer.
//    - States IDLE -> START -> DATA -> STOP -> IDLE.
//    - A falling edge in IDLE starts the frame. The start bit is re-checked at DIV/2; if high, return to IDLE.
//    - Data bits are sampled every DIV clocks after that, followed by the stop sample.
//    - Stop sample = 0: set RX_FERR and discard the byte.
//    - Good byte with RX_VALID=0: load the holder and set RX_VALID.
//    - Good byte with RX_VALID=1: keep the old byte, drop the new one, set RX_OVR.
//    - A DATA read and a byte completion in the same cycle: the read returns the old byte,
//      the new byte is loaded, RX_VALID stays 1, and RX_OVR is not set.
//  Reset mid-frame aborts both FSMs; uart_tx is 1 from the cycle after reset is sampled.
// CONFIGURATION
//  IOMEM_UART_RX_EN defined: the receiver is built as described above.
//  IOMEM_UART_RX_EN undefined: no receiver logic; uart_rx is ignored; STATUS[3], [5] and [6] read 0;
//    DATA reads always return 32'hFFFFFFFF.
// TESTING
//  T1 Reset, then read STATUS, DIV, DATA -> 0x00000002, 0x00000068, 0xFFFFFFFF; uart_tx=1 throughout.
//  T2 Write DIV=16, then DATA=0x55 -> uart_tx low 16 clks, then bits 1,0,1,0,1,0,1,0 at 16 clks each, then stop high;
//     160 clks total; STATUS then reads 0x2.
//  T3 DIV=16, write DATA 10 times back to back -> 9 bytes accepted (1 in shifter + 8 in FIFO), TX_OVF=1 (STATUS=0x15);
//     write STATUS=0x10 -> TX_OVF=0.
//  T4 RX_EN, DIV=16, drive frame 0xA5 -> RX_VALID=1; DATA read returns 0x000000A5; next DATA read returns 0xFFFFFFFF.
//  T5 RX_EN: a frame with stop=0 sets RX_FERR with RX_VALID=0.
//     Two good frames (0x11, then 0x22) without reads -> RX_OVR=1 and DATA read returns 0x00000011.
//  T6 iomem_valid held 3 cycles on a DATA write -> iomem_ready pulses once and one byte is pushed.
//     Assert rst mid-frame -> uart_tx=1 the next cycle and STATUS=0x2.

Source files
------------

// File: rtl/iomem_uart.sv
// iomem-bus UART: 8N1 transmitter fed by a TX FIFO, optional receiver with a 1-byte holder.
// Define IOMEM_UART_RX_EN to build the receiver; otherwise uart_rx is ignored.
module iomem_uart #(
   parameter int TX_FIFO_DEPTH = 3,
   parameter int DIV_RESET     = 104
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [31:0] iomem_addr,
   output logic [31:0] iomem_rdata,
   input  logic [31:0] iomem_wdata,
   input  logic [3:0]  iomem_wstrb,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int FIFO_N = 1 << TX_FIFO_DEPTH;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
   typedef logic [TX_FIFO_DEPTH:0] ptr_t;

   // Handshake: an access happens on an edge with iomem_valid=1 and iomem_ready=0; iomem_ready
   // and iomem_rdata are registered at that edge and every side effect commits there too, so
   // the ready pulse always lasts one cycle and the following edge cannot start a second access.
   logic        access, wr_req, rd_req;
   logic [1:0]  reg_sel;
   logic        push_req, status_w1c, rx_rd_clr;
   logic [31:0] rd_val;

   assign access     = iomem_valid & ~iomem_ready;
   assign reg_sel    = iomem_addr[3:2];
   assign wr_req     = access & (iomem_wstrb != 4'h0);
   assign rd_req     = access & (iomem_wstrb == 4'h0);
   assign push_req   = wr_req & (reg_sel == 2'd0) & iomem_wstrb[0];
   assign status_w1c = wr_req & (reg_sel == 2'd1) & iomem_wstrb[0];
   assign rx_rd_clr  = rd_req & (reg_sel == 2'd0);

   // ---------------- DIV register ----------------
   logic [15:0] div, div_wr;

   always_comb begin
      div_wr = div;
      if (iomem_wstrb[0]) div_wr[7:0]  = iomem_wdata[7:0];
      if (iomem_wstrb[1]) div_wr[15:8] = iomem_wdata[15:8];
   end

   always_ff @(posedge clk) begin
      if (rst)
         div <= 16'(DIV_RESET);
      else if (wr_req && reg_sel == 2'd2)
         div <= (div_wr < 16'd4) ? 16'd4 : div_wr;
   end

   // ---------------- TX FIFO ----------------
   logic [7:0] fifo_mem [FIFO_N];
   ptr_t       wr_ptr, rd_ptr;
   logic       tx_full, tx_empty, tx_pop, tx_ovf;

   assign tx_empty = (wr_ptr == rd_ptr);
   assign tx_full  = (wr_ptr[TX_FIFO_DEPTH] != rd_ptr[TX_FIFO_DEPTH]) &&
                     (wr_ptr[TX_FIFO_DEPTH-1:0] == rd_ptr[TX_FIFO_DEPTH-1:0]);

   always_ff @(posedge clk) begin
      if (push_req && !tx_full)
         fifo_mem[wr_ptr[TX_FIFO_DEPTH-1:0]] <= iomem_wdata[7:0];
   end

   // Full is judged before any pop at the same edge, so a push against a full FIFO is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         tx_ovf <= 1'b0;
      end else begin
         if (push_req) begin
            if (tx_full) tx_ovf <= 1'b1;
            else         wr_ptr <= wr_ptr + ptr_t'(1);
         end else if (status_w1c && iomem_wdata[4]) begin
            tx_ovf <= 1'b0;
         end
         if (tx_pop) rd_ptr <= rd_ptr + ptr_t'(1);
      end
   end

   // ---------------- TX FSM ----------------
   uart_state_t tx_state;
   logic [15:0] tx_cnt, tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shreg;
   logic        tx_bit_end, tx_busy;

   assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
   // The end of a stop bit may launch the next frame directly, leaving no idle gap.
   assign tx_pop     = !tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_bit_end));
   assign tx_busy    = !tx_empty || (tx_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         uart_tx  <= 1'b1;
         tx_cnt   <= 16'd0;
         tx_div   <= 16'd4;
         tx_bit   <= 3'd0;
         tx_shreg <= 8'd0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               if (tx_pop) begin
                  tx_shreg <= fifo_mem[rd_ptr[TX_FIFO_DEPTH-1:0]];
                  tx_div   <= div;
                  tx_cnt   <= 16'd0;
                  uart_tx  <= 1'b0;
                  tx_state <= S_START;
               end
            end
            S_START: begin
               if (tx_bit_end) begin
                  tx_cnt   <= 16'd0;
                  uart_tx  <= tx_shreg[0];
                  tx_shreg <= {1'b0, tx_shreg[7:1]};
                  tx_bit   <= 3'd0;
                  tx_state <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= 16'd0;
                  if (tx_bit == 3'd7) begin
                     uart_tx  <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     uart_tx  <= tx_shreg[0];
                     tx_shreg <= {1'b0, tx_shreg[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            default: begin
               if (tx_bit_end) begin
                  tx_cnt <= 16'd0;
                  if (tx_pop) begin
                     tx_shreg <= fifo_mem[rd_ptr[TX_FIFO_DEPTH-1:0]];
                     tx_div   <= div;
                     uart_tx  <= 1'b0;
                     tx_state <= S_START;
                  end else begin
                     tx_state <= S_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // ---------------- RX ----------------
   logic [7:0] rx_byte;
   logic       rx_valid, rx_ovr, rx_ferr;
   logic       unused_ok;

`ifdef IOMEM_UART_RX_EN
   uart_state_t rx_state;
   logic        rx_s1, rx_s2, rx_d;
   logic [15:0] rx_cnt, rx_div;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shreg;
   logic        rx_bit_end;

   assign rx_bit_end = (rx_cnt == rx_div - 16'd1);
   assign unused_ok  = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:16], iomem_wstrb[3:2]};

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   // Completion updates are written after the bus clears so a same-edge read and a finished
   // byte leave the new byte loaded with RX_VALID still set and no overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= S_IDLE;
         rx_cnt   <= 16'd0;
         rx_div   <= 16'd4;
         rx_bit   <= 3'd0;
         rx_shreg <= 8'd0;
         rx_byte  <= 8'd0;
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         if (rx_rd_clr) rx_valid <= 1'b0;
         if (status_w1c && iomem_wdata[5]) rx_ovr  <= 1'b0;
         if (status_w1c && iomem_wdata[6]) rx_ferr <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rx_d && !rx_s2) begin
                  rx_cnt   <= 16'd0;
                  rx_div   <= div;
                  rx_state <= S_START;
               end
            end
            S_START: begin
               if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                  rx_cnt <= 16'd0;
                  rx_bit <= 3'd0;
                  rx_state <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (rx_bit_end) begin
                  rx_cnt   <= 16'd0;
                  rx_shreg <= {rx_s2, rx_shreg[7:1]};
                  if (rx_bit == 3'd7) rx_state <= S_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: begin
               if (rx_bit_end) begin
                  rx_cnt   <= 16'd0;
                  rx_state <= S_IDLE;
                  if (!rx_s2) begin
                     rx_ferr <= 1'b1;
                  end else if (!rx_valid || rx_rd_clr) begin
                     rx_byte  <= rx_shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_ovr <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
         endcase
      end
   end
`else
   assign rx_byte   = 8'd0;
   assign rx_valid  = 1'b0;
   assign rx_ovr    = 1'b0;
   assign rx_ferr   = 1'b0;
   assign unused_ok = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:16], iomem_wdata[6:5],
                        iomem_wstrb[3:2], uart_rx, rx_rd_clr};
`endif

   // ---------------- Register read and bus response ----------------
   always_comb begin
      rd_val = 32'h0;
      case (reg_sel)
         2'd0:    rd_val = rx_valid ? {24'h0, rx_byte} : 32'hFFFF_FFFF;
         2'd1:    rd_val = {25'h0, rx_ferr, rx_ovr, tx_ovf, rx_valid, tx_busy, tx_empty, tx_full};
         2'd2:    rd_val = {16'h0, div};
         default: rd_val = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'h0;
      end else if (access) begin
         iomem_ready <= 1'b1;
         iomem_rdata <= rd_val;
      end else begin
         iomem_ready <= 1'b0;
      end
   end

endmodule
